// File: rtl/piso_rr_scheduler.sv
// piso_rr_scheduler: round-robin arbiter in front of one shared PISO shifter.
// It grants one requester at a time, captures that requester's word, and
// shifts the word out LSB-first with valid/first framing. Back-to-back frames
// have no gap between them.
module piso_rr_scheduler #(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 4,
  localparam int OW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   datain,
  output logic [N_REQ-1:0]         gnt,
  output logic                     dataout,
  output logic                     valid,
  output logic                     first,
  output logic [OW-1:0]            owner,
  output logic                     busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic                dataout_q, dataout_d;
  logic                valid_q, valid_d;
  logic                first_q, first_d;

  logic                win_found;
  logic [OW-1:0]       win_idx;
  logic [OW-1:0]       cand_idx;
  logic [N_REQ-1:0]    win_oh;
  logic [WIDTH-1:0]    win_word;
  logic                decision;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = {OW{1'b0}};
    cand_idx  = {OW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = OW'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end else begin
        win_found = win_found;
      end
    end
  end

  // One-hot of the winner and a mux of its word out of the packed input bus.
  always_comb begin
    win_oh   = {N_REQ{1'b0}};
    win_word = {WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      win_oh[i] = win_found && (win_idx == OW'(i));
      win_word  = win_word | (datain[i*WIDTH +: WIDTH] & {WIDTH{win_oh[i]}});
    end
  end

  // Next-state: capture at a decision edge, otherwise keep shifting.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = {N_REQ{1'b0}};
    decision = (state_q == ST_IDLE) || (cnt_q == CW'(WIDTH - 1));
    if (decision) begin
      if (win_found) begin
        sh_d    = win_word;
        cnt_d   = {CW{1'b0}};
        ptr_d   = win_idx;
        owner_d = win_idx;
        gnt_d   = win_oh;
        state_d = ST_SHIFT;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      sh_d  = sh_q >> 1;
      cnt_d = cnt_q + CW'(1);
    end
    valid_d   = (state_d == ST_SHIFT);
    dataout_d = valid_d & sh_d[0];
    first_d   = valid_d && (cnt_d == {CW{1'b0}});
  end

  // State, shifter and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      sh_q      <= {WIDTH{1'b0}};
      cnt_q     <= {CW{1'b0}};
      ptr_q     <= OW'(N_REQ - 1);
      owner_q   <= {OW{1'b0}};
      gnt_q     <= {N_REQ{1'b0}};
      dataout_q <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
    end
  end

  assign gnt     = gnt_q;
  assign dataout = dataout_q;
  assign valid   = valid_q;
  assign first   = first_q;
  assign owner   = owner_q;
  assign busy    = valid_q;

endmodule

// File: tb/tb_piso_rr_scheduler.sv
// Bench for piso_rr_scheduler: a frame-level reference model pushes the
// expected serial bits into a queue, and a monitor pops and compares them.
module tb_piso_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int OW = 2;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [N-1:0]  req = '0;
  logic [DW-1:0] datain = '0;
  logic [N-1:0]  gnt;
  logic          dataout, valid, first, busy;
  logic [OW-1:0] owner;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          d;
    logic          f;
    logic [OW-1:0] o;
    logic [N-1:0]  g;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  piso_rr_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .req(req), .datain(datain),
    .gnt(gnt), .dataout(dataout), .valid(valid), .first(first),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view. A frame lasts W cycles; when the frame
  // ends (or the block is idle) the next winner is picked round-robin after
  // the last granted requester and its whole frame is queued bit by bit.
  initial begin
    int left;
    int last;
    int win;
    bit found;
    logic [W-1:0] word;
    exp_t e;
    left = 0;
    last = N - 1;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        exp_q.delete();
        left = 0;
        last = N - 1;
      end else if (left <= 1) begin
        found = 1'b0;
        win   = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && (((req >> ((last + k) % N)) & 1) != 0)) begin
            found = 1'b1;
            win   = (last + k) % N;
          end
        end
        if (found) begin
          word = W'(datain >> (win * W));
          for (int b = 0; b < W; b++) begin
            e.d = word[b];
            e.f = (b == 0);
            e.o = OW'(win);
            e.g = (b == 0) ? N'(1 << win) : '0;
            exp_q.push_back(e);
          end
          left = W;
          last = win;
        end else begin
          left = 0;
        end
      end else begin
        left = left - 1;
      end
    end
  end

  // Monitor: compare outputs mid-cycle against the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_valid", valid, 0);
        check("rst_dataout", dataout, 0);
        check("rst_gnt", gnt, 0);
      end else if (valid) begin
        for (int i = 0; i < N; i++)
          if (((gnt >> i) & 1) != 0) grant_log.push_back(i);
        if (exp_q.size() == 0) begin
          check("unexpected_frame_bit", valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("dataout", dataout, e.d);
          check("first", first, e.f);
          check("owner", owner, e.o);
          check("gnt", gnt, e.g);
          check("busy", busy, valid);
        end
      end else begin
        check("idle_gnt", gnt, 0);
        check("idle_dataout", dataout, 0);
        check("idle_first", first, 0);
        check("idle_busy", busy, 0);
        check("missing_frame_bits", exp_q.size(), 0);
      end
    end
  end

  task automatic run_auto(input int n);
    repeat (n) begin
      @(negedge clk);
      req = req & ~gnt;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    req = '0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_owner", owner, 0);
    check("reset_first", first, 0);
    check("reset_busy", busy, 0);
    check("reset_gnt", gnt, 0);
    #1 reset = 1'b1;

    // Single request from requester 2, word 1011.
    datain = {4'h0, 4'b1011, 4'h0, 4'h0};
    req = 4'b0100;
    grant_log.delete();
    run_auto(8);
    check("single_grants", grant_log.size(), 1);
    if (grant_log.size() > 0) check("single_owner", grant_log[0], 2);
    check("single_end_valid", valid, 0);

    // Round-robin fairness with all requesters held.
    do_reset();
    datain = {4'd8, 4'd4, 4'd2, 4'd1};
    req = 4'b1111;
    grant_log.delete();
    repeat (8 * W) @(negedge clk);
    req = '0;
    repeat (W + 2) @(negedge clk);
    check("rr_grant_count", grant_log.size(), 2 * N);
    foreach (grant_log[k]) check("rr_order", grant_log[k], k % N);

    // Pointer rotation: after granting 1, requesters {0,1} go 0 then 1.
    do_reset();
    req = 4'b0010;
    grant_log.delete();
    run_auto(2);
    req = 4'b0011;
    run_auto(3 * W);
    check("rot_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("rot_0", grant_log[0], 1);
      check("rot_1", grant_log[1], 0);
      check("rot_2", grant_log[2], 1);
    end

    // Withdrawal: requester 2 drops before its turn.
    do_reset();
    req = 4'b0110;
    grant_log.delete();
    run_auto(1);
    @(negedge clk);
    req = '0;
    run_auto(2 * W);
    check("wd_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("wd_owner", grant_log[0], 1);
    check("wd_idle", valid, 0);

    // Reset asserted at bit 2 of a frame.
    do_reset();
    datain = 16'h000F;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_dataout", dataout, 0);
    check("midrst_gnt", gnt, 0);
    check("midrst_first", first, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    grant_log.delete();
    datain = {4'b1101, 12'h000};
    req = 4'b1000;
    run_auto(W + 3);
    check("midrst_regrant_count", grant_log.size(), 1);
    if (grant_log.size() > 0) check("midrst_regrant_owner", grant_log[0], 3);

    // Random traffic: requests rise, withdraw, re-request; data churns every cycle.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      datain = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = ($urandom_range(0, 1) == 1);
        else if (req[i]) req[i] = ($urandom_range(0, 15) != 0);
        else req[i] = ($urandom_range(0, 3) == 0);
      end
    end
    req = '0;
    repeat (2 * W + 2) @(negedge clk);
    check("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_rr_scheduler.md
# piso_rr_scheduler

Round-robin scheduler that shares one parallel-in/serial-out shifter between N_REQ requesters. Each requester presents a parallel word and a request. The block grants one requester at a time, captures that word, and shifts it out LSB-first on a single serial line with framing strobes. It sits between several word producers and one serial link, and owns both the arbitration state and the shifter.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 4, bits per word (≥2)
- OW, $clog2(N_REQ), width of owner index (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester request level, held until granted
- datain  input  N_REQ*WIDTH  packed words, requester i at [i*WIDTH +: WIDTH]
- gnt  output  N_REQ  registered one-hot pulse, one cycle, marks capture of that requester's word
- dataout  output  1  serial data, LSB first
- valid  output  1  dataout carries a frame bit
- first  output  1  high on bit 0 of each frame
- owner  output  OW  index of requester whose frame is on dataout
- busy  output  1  equals valid

## Operation
- States: IDLE, SHIFT. Internal: shifter sh[WIDTH-1:0], bit counter cnt, round-robin pointer ptr = last granted index.
- Reset (reset=0, asynchronous): state IDLE; sh=0, cnt=0, ptr=N_REQ-1 (requester 0 highest priority first); gnt=0, dataout=0, valid=0, first=0, owner=0, busy=0.
- Decision point: an edge where state=IDLE, or state=SHIFT with cnt=WIDTH-1. No other edge samples req.
- At a decision point with req≠0: the winner is the first set req bit searching ptr+1, ptr+2, … modulo N_REQ. On that edge:
  - sh ← winner's word
  - cnt ← 0
  - ptr ← winner
  - owner ← winner
  - gnt ← one-hot(winner)
  - state ← SHIFT
- At a decision point with req=0: state ← IDLE, valid ← 0, dataout ← 0, gnt ← 0. ptr and owner hold.
- In SHIFT at a non-decision edge: sh ← sh>>1, cnt ← cnt+1, gnt ← 0.
- dataout = sh[0] while valid. valid=1 in SHIFT. first=1 when cnt=0 in SHIFT.
- datain is sampled only at capture. Later changes do not affect the frame in flight.
- A requester may drop req before it is granted (withdrawal). It then receives no grant and produces no frame.
- A requester that still holds req at its next decision point is treated as a new request and waits its round-robin turn.
- Lowering req on the cycle gnt is high guarantees no second grant.
- gnt is never high in IDLE. At most one gnt bit is set in any cycle.

## Timing
- Grant latency: req seen at a decision edge E gives, in the cycle after E, gnt[i]=1, valid=1, first=1, dataout=word[0], owner=i.
- Frame length: exactly WIDTH cycles. Bit k appears in cycle k after capture.
- Back-to-back: with a request pending at the last-bit edge, the next frame's bit 0 follows the previous frame's bit WIDTH-1 with zero gap, so valid stays high.
- Minimum spacing of grants to the same requester: WIDTH cycles. With N_REQ requesters all busy: N_REQ*WIDTH cycles.
- Reset asserted mid-frame: outputs clear immediately (asynchronous) and the frame is abandoned. After release, the block starts in IDLE with ptr=N_REQ-1, and the aborted requester's word is not resumed.

## Test plan
- Single request: reset, then req=4'b0100 with word2=4'b1011 → one cycle later gnt=4'b0100, first=1, owner=2. dataout=1,1,0,1 over 4 cycles with valid=1. Then valid=0 and dataout=0.
- Round-robin fairness: req=4'b1111 held with words 1,2,4,8 → grants in order 0,1,2,3,0,… each 4 cycles apart. valid stays continuously high. first pulses every 4th cycle.
- Pointer rotation: grant 1, then req=4'b0011 at the next decision → requester 0 is granted? No: requester 1 is ptr, so the search starts at 2 and requester 0 is granted, then 1.
- Withdrawal: req=4'b0110 at a decision, requester 2 waiting, drop req[2] mid-frame → at the next decision with req=0, no gnt[2] and the block goes to IDLE.
- Reset mid-frame: assert reset at bit 2 → same-cycle valid=0, dataout=0, gnt=0. After release, req=4'b1000 → owner=3 with a full 4-bit frame.
- Data stability: change datain during shifting → the serial bits equal the word captured at grant.
